// File: rtl/lcd_sequencer.sv
// HD44780-style LCD write sequencer: power-on init sequence, then single-byte
// command/data transfers with a registered E strobe and per-command busy delays.
module lcd_sequencer #(
  parameter int unsigned CLOCK        = 50000000,
  parameter logic [7:0]  FUNCTION_SET = 8'h38,
  parameter logic [7:0]  ENTRY_MODE   = 8'h06,
  parameter logic [7:0]  DISPLAY_ON   = 8'h0C
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_e
);

  // Cycle count for CLOCK*num/den seconds, truncated, never below 1.
  function automatic int unsigned dly(input longint unsigned clk_hz,
                                      input longint unsigned num,
                                      input longint unsigned den);
    longint unsigned v;
    v = (clk_hz * num) / den;
    return (v == 64'd0) ? 32'd1 : v[31:0];
  endfunction

  localparam int unsigned T15   = dly(CLOCK, 15, 1000);
  localparam int unsigned T4100 = dly(CLOCK, 41, 10000);
  localparam int unsigned T100  = dly(CLOCK, 1, 10000);
  localparam int unsigned T37   = dly(CLOCK, 37, 1000000);
  localparam int unsigned T1530 = dly(CLOCK, 153, 100000);
  localparam int unsigned TMAX  = (T15 > T1530) ? T15 : T1530;
  localparam int          CW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    POWER_WAIT, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] wait_m1, wait_m1_d;
  logic [2:0]    idx, idx_d;
  logic          rs, rs_d;
  logic [7:0]    data, data_d;
  logic          init_done, init_done_d;
  logic          e, e_d;

  logic [2:0]    rom_sel;
  logic [7:0]    rom_byte;
  logic [CW-1:0] rom_wait_m1;
  logic          long_cmd;

  // The next init byte is looked up directly, so LOAD never costs a cycle.
  assign rom_sel = (state == POWER_WAIT) ? 3'd0 : idx + 3'd1;

  always_comb begin
    rom_byte    = DISPLAY_ON;
    rom_wait_m1 = CW'(T37 - 1);
    case (rom_sel)
      3'd0: begin rom_byte = 8'h30;        rom_wait_m1 = CW'(T4100 - 1); end
      3'd1: begin rom_byte = 8'h30;        rom_wait_m1 = CW'(T100 - 1);  end
      3'd2: begin rom_byte = 8'h30;        rom_wait_m1 = CW'(T37 - 1);   end
      3'd3: begin rom_byte = FUNCTION_SET; rom_wait_m1 = CW'(T37 - 1);   end
      3'd4: begin rom_byte = 8'h08;        rom_wait_m1 = CW'(T37 - 1);   end
      3'd5: begin rom_byte = 8'h01;        rom_wait_m1 = CW'(T1530 - 1); end
      3'd6: begin rom_byte = ENTRY_MODE;   rom_wait_m1 = CW'(T37 - 1);   end
      default: begin rom_byte = DISPLAY_ON; rom_wait_m1 = CW'(T37 - 1);  end
    endcase
  end

  // Clear display (0x01) and return home (0x02/0x03) need the long busy time.
  assign long_cmd = !i_rs && (((i_data[7:1] == 7'd0) && i_data[0]) ||
                              (i_data[7:1] == 7'd1));

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wait_m1_d   = wait_m1;
    idx_d       = idx;
    rs_d        = rs;
    data_d      = data;
    init_done_d = init_done;
    case (state)
      POWER_WAIT, WAIT: begin
        if (cnt == ((state == POWER_WAIT) ? CW'(T15 - 1) : wait_m1)) begin
          cnt_d = '0;
          if (state == POWER_WAIT || (!init_done && idx != 3'd7)) begin
            state_d   = SETUP;
            idx_d     = rom_sel;
            rs_d      = 1'b0;
            data_d    = rom_byte;
            wait_m1_d = rom_wait_m1;
          end else begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      SETUP: state_d = PULSE;
      PULSE: state_d = HOLD;
      HOLD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      IDLE: begin
        if (i_valid) begin
          state_d   = SETUP;
          rs_d      = i_rs;
          data_d    = i_data;
          wait_m1_d = long_cmd ? CW'(T1530 - 1) : CW'(T37 - 1);
        end
      end
      default: state_d = POWER_WAIT;
    endcase
    e_d = (state_d == PULSE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= POWER_WAIT;
      cnt       <= '0;
      wait_m1   <= '0;
      idx       <= '0;
      rs        <= 1'b0;
      data      <= '0;
      init_done <= 1'b0;
      e         <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wait_m1   <= wait_m1_d;
      idx       <= idx_d;
      rs        <= rs_d;
      data      <= data_d;
      init_done <= init_done_d;
      e         <= e_d;
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_init_done = init_done;
  assign o_lcd_rs    = rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data;
  assign o_lcd_e     = e;

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter CLOCK, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter FUNCTION_SET, default 8'h38, function-set byte issued during init.
REQ-003 SHALL have parameter ENTRY_MODE, default 8'h06, entry-mode byte issued during init.
REQ-004 SHALL have parameter DISPLAY_ON, default 8'h0C, display-control byte issued last in init.
REQ-005 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_valid  input  1  user byte request.
REQ-008 SHALL have port i_rs  input  1  register select of the request (0 command, 1 data).
REQ-009 SHALL have port i_data  input  8  byte of the request.
REQ-010 SHALL have port o_ready  output  1  sequencer can accept a request this cycle.
REQ-011 SHALL have port o_init_done  output  1  power-on init sequence finished.
REQ-012 SHALL have port o_lcd_rs  output  1  LCD RS pin.
REQ-013 SHALL have port o_lcd_rw  output  1  LCD RW pin, constant 0 (write only).
REQ-014 SHALL have port o_lcd_data  output  8  LCD DB7..DB0.
REQ-015 SHALL have port o_lcd_e  output  1  LCD enable strobe, registered, glitch-free.

Function
REQ-016 Delays SHALL be cycle counts D(t) = max(1, integer(CLOCK*t)): T15=D(15ms), T4100=D(4.1ms), T100=D(100us), T37=D(37us), T1530=D(1.53ms).
REQ-017 FSM states SHALL be POWER_WAIT, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
REQ-018 After reset release, POWER_WAIT SHALL last exactly T15 cycles, then go to LOAD with init index 0.
REQ-019 Init table SHALL be, as (RS=0 byte, post-delay): 0x30 T4100; 0x30 T100; 0x30 T37; FUNCTION_SET T37; 0x08 T37; 0x01 T1530; ENTRY_MODE T37; DISPLAY_ON T37.
REQ-020 Each byte transfer SHALL be: SETUP 1 cycle (rs/data driven, E=0), PULSE 1 cycle (E=1), HOLD 1 cycle (E=0, bus unchanged), WAIT exactly post-delay cycles.
REQ-021 o_lcd_rs and o_lcd_data SHALL be stable from SETUP through end of WAIT, and SHALL hold their last value while IDLE.
REQ-022 LOAD SHALL be zero-cycle (combined with SETUP entry) or merged so that consecutive init bytes are separated by exactly 3 + post-delay cycles.
REQ-023 After WAIT of the 8th init byte, FSM SHALL enter IDLE; o_init_done SHALL go 1 and stay 1 until reset.
REQ-024 o_ready SHALL be 1 only in IDLE.
REQ-025 Request SHALL be accepted on an edge where o_ready=1 and i_valid=1; i_rs/i_data latched on that edge; next cycle is SETUP.
REQ-026 i_valid while o_ready=0 SHALL be ignored; no queueing.
REQ-027 User post-delay SHALL be T1530 when i_rs=0 and i_data[7:1]==7'b0000000 with i_data[0]=1 (clear) or i_data[7:1]==7'b0000001 (return home); otherwise T37.
REQ-028 For acceptance on edge N, E SHALL be high only in cycle N+2, o_ready SHALL be 1 again in cycle N+4+delay.
REQ-029 A request presented in the first cycle o_ready returns to 1 SHALL be accepted (back-to-back allowed).
REQ-030 Delay counter SHALL be wide enough for max(T15,T1530) without wrap; it SHALL never wrap during WAIT.

Reset
REQ-031 Reset asserted: o_ready=0, o_init_done=0, o_lcd_e=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=8'h00, state POWER_WAIT, counter 0, init index 0.
REQ-032 Reset asserted mid-transfer (including during PULSE) SHALL drop E immediately and restart full init after release.

Verification (CLOCK=100000: T15=1500, T4100=410, T100=10, T37=3, T1530=153)
REQ-033 Release reset, i_valid=0 -> E pulses exactly 8 times with bytes 30,30,30,38,08,01,06,0C; o_init_done and o_ready rise 2112 cycles after release.
REQ-034 After init, i_valid=1, i_rs=1, i_data=8'h41 for one cycle -> E high in cycle N+2 only, RS=1, data=41, o_ready back at N+7.
REQ-035 After init, command 8'h01 then 8'h02 back-to-back -> each occupies 156 cycles busy (o_ready at N+157).
REQ-036 i_valid held high during init and during busy -> no extra E pulses, first accept exactly when o_ready rises.
REQ-037 Assert i_rst_n=0 in PULSE of 4th init byte -> E falls same cycle, all outputs reset values; after release full 2112-cycle init repeats.
